aes_out_ctrl_intel: RTL

AES_OUT_CTRL_INTEL -- requirements
Module: aes_out_ctrl_intel

---
 rtl/aes_out_ctrl_intel_if.sv | 14 +
 rtl/aes_out_ctrl_intel.sv | 129 ++++++++++++
 2 files changed

// File: rtl/aes_out_ctrl_intel_if.sv
// Downstream payload stream of the AES output controller: FWFT head with
// valid/ready handshake.
interface aes_out_ctrl_intel_if #(
  parameter int N_PIPES = 4
);
  logic [N_PIPES*128-1:0] odata;
  logic [N_PIPES*16-1:0]  okeep;
  logic                   olast;
  logic                   ovalid;
  logic                   iready;

  modport master (output odata, okeep, olast, ovalid, input iready);
  modport slave  (input odata, okeep, olast, ovalid, output iready);
endinterface

// File: rtl/aes_out_ctrl_intel.sv
// AES output controller: mode-dependent post-XOR stage, CBC-encrypt IV feedback,
// FWFT output FIFO with credit-style oready, sticky overflow flag and beat counter.
module aes_out_ctrl_intel #(
  parameter int N_PIPES    = 4,
  parameter int MODE       = 0,
  parameter int OPERATION  = 0,
  parameter int FIFO_DEPTH = 16,
  parameter int SLACK      = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ivalid,
  input  logic [N_PIPES*128-1:0] idata,
  input  logic [N_PIPES*128-1:0] iaux,
  input  logic [N_PIPES*16-1:0]  ikeep,
  input  logic                   ilast,
  output logic                   oready,
  aes_out_ctrl_intel_if.master   m_axis,
  output logic [127:0]           ofeedbackiv,
  output logic                   ofeedbackvalid,
  output logic                   oerr,
  output logic [31:0]            obeats
);
  localparam int DW = N_PIPES * 128;
  localparam int KW = N_PIPES * 16;
  localparam int EW = DW + KW + 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam bit USE_XOR = (MODE == 1) || ((MODE == 2) && (OPERATION == 1));
  localparam bit CBC_ENC = (MODE == 2) && (OPERATION == 0);
  localparam logic [AW+1:0] OCC_LIMIT = (AW+2)'(FIFO_DEPTH - SLACK);
  localparam logic [AW:0]   FULL_CNT  = (AW+1)'(FIFO_DEPTH);

  logic [DW-1:0] result;

  // CTR and CBC-decrypt recover the payload by XOR with the side data per lane.
  for (genvar gi = 0; gi < N_PIPES; gi++) begin : g_lane
    assign result[gi*128 +: 128] = USE_XOR ? (idata[gi*128 +: 128] ^ iaux[gi*128 +: 128])
                                           : idata[gi*128 +: 128];
  end

  logic          s1_valid_reg;
  logic [DW-1:0] s1_data_reg;
  logic [KW-1:0] s1_keep_reg;
  logic          s1_last_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_reg <= 1'b0;
      s1_data_reg  <= '0;
      s1_keep_reg  <= '0;
      s1_last_reg  <= 1'b0;
    end else begin
      s1_valid_reg <= ivalid;
      if (ivalid) begin
        s1_data_reg <= result;
        s1_keep_reg <= ikeep;
        s1_last_reg <= ilast;
      end
    end
  end

  // In CBC encrypt the stage-1 word is the raw ciphertext, so its top lane is the next IV.
  assign ofeedbackvalid = CBC_ENC ? s1_valid_reg : 1'b0;
  assign ofeedbackiv    = CBC_ENC ? s1_data_reg[DW-1 -: 128] : '0;

  logic [EW-1:0]  mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr_reg;
  logic [AW-1:0]  rd_ptr_reg;
  logic [AW:0]    count_reg;
  logic [AW:0]    count_next;
  logic [AW+1:0]  occ_next;
  logic           oerr_reg;
  logic [31:0]    obeats_reg;
  logic           oready_reg;
  logic           full;
  logic           pop;
  logic           wr_en;
  logic [EW-1:0]  head;

  assign full  = (count_reg == FULL_CNT);
  assign pop   = m_axis.ovalid && m_axis.iready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign wr_en = s1_valid_reg && (!full || pop);

  always_comb begin
    count_next = count_reg;
    case ({wr_en, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  assign occ_next = {1'b0, count_next} + (AW+2)'(ivalid);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      oerr_reg   <= 1'b0;
      obeats_reg <= '0;
      oready_reg <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
        obeats_reg <= obeats_reg + 32'd1;
      end
      count_reg <= count_next;
      if (s1_valid_reg && full && !pop) oerr_reg <= 1'b1;
      oready_reg <= (occ_next <= OCC_LIMIT);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_reg] <= {s1_last_reg, s1_keep_reg, s1_data_reg};
  end

  assign head          = mem[rd_ptr_reg];
  assign m_axis.ovalid = (count_reg != '0);
  assign m_axis.odata  = m_axis.ovalid ? head[DW-1:0]  : '0;
  assign m_axis.okeep  = m_axis.ovalid ? head[DW +: KW] : '0;
  assign m_axis.olast  = m_axis.ovalid && head[EW-1];

  assign oready = oready_reg;
  assign oerr   = oerr_reg;
  assign obeats = obeats_reg;
endmodule
